vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_axis_counter.sv | 38 +++
 rtl/vga_timing_gen.sv | 117 +++++++++++
 tb/tb_vga_timing_gen.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg : default 640x480@60 timing constants and the timing record type.
// Rev 1.0
// ============================================================================
package vga_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam vga_timing_t VGA_640X480_V = '{active: 480, fp: 10, sync: 2,  bp: 33};

  function automatic int unsigned timing_total(input vga_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// vga_axis_counter : modulo-TOTAL counter with increment, clear and wrap flag.
// Rev 1.0
// ============================================================================
module vga_axis_counter #(
  parameter int unsigned TOTAL = 800,
  parameter int unsigned W     = 10
) (
  input  logic         clk25,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  if ((TOTAL < 2) || (TOTAL > (2 ** W))) begin : g_bad_total
    $error("vga_axis_counter: TOTAL does not fit in W bits");
  end

  assign wrap = inc && (count == LAST);

  // Clear has priority over a wrap landing in the same cycle.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : VGA raster counters with registered sync/blank/pulse decode.
// Rev 1.0
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_640X480_H.active,
  parameter int unsigned H_FP     = VGA_640X480_H.fp,
  parameter int unsigned H_SYNC   = VGA_640X480_H.sync,
  parameter int unsigned H_BP     = VGA_640X480_H.bp,
  parameter int unsigned V_ACTIVE = VGA_640X480_V.active,
  parameter int unsigned V_FP     = VGA_640X480_V.fp,
  parameter int unsigned V_SYNC   = VGA_640X480_V.sync,
  parameter int unsigned V_BP     = VGA_640X480_V.bp,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CNT_W    = 10
) (
  input  logic             clk25,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             restart,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             hsync,
  output logic             vsync,
  output logic             video_active,
  output logic             line_start,
  output logic             frame_start
);

  localparam vga_timing_t H_TIM = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam vga_timing_t V_TIM = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int unsigned H_TOTAL = timing_total(H_TIM);
  localparam int unsigned V_TOTAL = timing_total(V_TIM);

  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             x_wrap;
  logic             y_wrap;
  logic             at_origin;
  logic             in_hs;
  logic             in_vs;
  logic             in_active;

  vga_axis_counter #(
    .TOTAL (H_TOTAL),
    .W     (CNT_W)
  ) u_x_cnt (
    .clk25 (clk25),
    .rst_n (rst_n),
    .inc   (ce),
    .clr   (restart),
    .count (x),
    .wrap  (x_wrap)
  );

  vga_axis_counter #(
    .TOTAL (V_TOTAL),
    .W     (CNT_W)
  ) u_y_cnt (
    .clk25 (clk25),
    .rst_n (rst_n),
    .inc   (x_wrap),
    .clr   (restart),
    .count (y),
    .wrap  (y_wrap)
  );

  assign in_hs     = (x >= HS_FIRST) && (x <= HS_LAST);
  assign in_vs     = (y >= VS_FIRST) && (y <= VS_LAST);
  assign in_active = (x < H_ACT_END) && (y < V_ACT_END);

  // Tracks "counters sit at (0,0)" so frame_start needs no wide compare.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      at_origin <= 1'b1;
    end else begin
      at_origin <= restart | y_wrap | (at_origin & ~ce);
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      pixel_x      <= '0;
      pixel_y      <= '0;
      hsync        <= ~H_POL;
      vsync        <= ~V_POL;
      video_active <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (ce) begin
        pixel_x      <= x;
        pixel_y      <= y;
        hsync        <= in_hs ? H_POL : ~H_POL;
        vsync        <= in_vs ? V_POL : ~V_POL;
        video_active <= in_active;
        line_start   <= (x == '0);
        frame_start  <= at_origin;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// tb_vga_timing_gen : default and reduced-timing instances against an index model.
// Rev 1.0
// ============================================================================
module tb_vga_timing_gen;

  localparam int unsigned B_HTOT  = 800;
  localparam int unsigned B_FRAME = 800 * 525;
  localparam int unsigned S_FRAME = 14 * 7;
  localparam logic [36:0] B_RST   = {16'd0, 16'd0, 1'b1, 1'b1, 3'b000};
  localparam logic [36:0] S_RST   = {16'd0, 16'd0, 1'b0, 1'b0, 3'b000};

  logic clk25 = 1'b0;
  logic rst_n, ce, restart;
  logic [9:0] bx, by;
  logic       bhs, bvs, bva, bls, bfs;
  logic [3:0] sx, sy;
  logic       shs, svs, sva, sls, sfs;

  int tests = 0;
  int fails = 0;
  int unsigned bidx, sidx;
  logic [36:0] bexp, sexp;

  always #20 clk25 = ~clk25;

  vga_timing_gen u_big (
    .clk25(clk25), .rst_n(rst_n), .ce(ce), .restart(restart),
    .pixel_x(bx), .pixel_y(by), .hsync(bhs), .vsync(bvs),
    .video_active(bva), .line_start(bls), .frame_start(bfs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CNT_W(4)
  ) u_small (
    .clk25(clk25), .rst_n(rst_n), .ce(ce), .restart(restart),
    .pixel_x(sx), .pixel_y(sy), .hsync(shs), .vsync(svs),
    .video_active(sva), .line_start(sls), .frame_start(sfs)
  );

  // Expected outputs for the raster position with linear index idx.
  function automatic logic [36:0] ref_out(input int unsigned idx,
      input int unsigned ha, input int unsigned hf, input int unsigned hs, input int unsigned hb,
      input int unsigned va, input int unsigned vf, input int unsigned vs,
      input bit hp, input bit vp);
    int unsigned htot, x, y;
    logic h_on, v_on;
    htot = ha + hf + hs + hb;
    x    = idx % htot;
    y    = idx / htot;
    h_on = (x >= ha + hf) && (x < ha + hf + hs);
    v_on = (y >= va + vf) && (y < va + vf + vs);
    return {16'(x), 16'(y), h_on ? hp : ~hp, v_on ? vp : ~vp,
            (x < ha) && (y < va), x == 0, idx == 0};
  endfunction

  function automatic logic [36:0] big_ref(input int unsigned idx);
    return ref_out(idx, 640, 16, 96, 48, 480, 10, 2, 1'b0, 1'b0);
  endfunction

  function automatic logic [36:0] small_ref(input int unsigned idx);
    return ref_out(idx, 8, 2, 2, 2, 4, 1, 1, 1'b1, 1'b1);
  endfunction

  function automatic logic [36:0] big_act();
    return {6'd0, bx, 6'd0, by, bhs, bvs, bva, bls, bfs};
  endfunction

  function automatic logic [36:0] small_act();
    return {12'd0, sx, 12'd0, sy, shs, svs, sva, sls, sfs};
  endfunction

  task automatic tick(input logic c, input logic r);
    ce = c;
    restart = r;
    @(posedge clk25);
    if (c) begin
      bexp = big_ref(bidx);
      sexp = small_ref(sidx);
    end else begin
      bexp[1:0] = 2'b00;
      sexp[1:0] = 2'b00;
    end
    if (r) begin
      bidx = 0;
      sidx = 0;
    end else if (c) begin
      bidx = (bidx + 1) % B_FRAME;
      sidx = (sidx + 1) % S_FRAME;
    end
    #1;
  endtask

  task automatic model_reset();
    bidx = 0; sidx = 0; bexp = B_RST; sexp = S_RST;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1; restart = 1'b0;
    model_reset();
    repeat (3) @(posedge clk25);
    #1;
    tests++;
    if (big_act() !== B_RST) begin fails++; $display("FAIL reset_big got=%h want=%h", big_act(), B_RST); end
    tests++;
    if (small_act() !== S_RST) begin fails++; $display("FAIL reset_small got=%h want=%h", small_act(), S_RST); end
  endtask

  task automatic test_first_edge();
    @(negedge clk25);
    rst_n = 1'b1;
    tick(1'b1, 1'b0);
    tests++;
    if ({bx, by, bfs, bls} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
      fails++; $display("FAIL first_edge x=%0d y=%0d fs=%b ls=%b want 0 0 1 1", bx, by, bfs, bls);
    end
    tick(1'b1, 1'b0);
    tests++;
    if (big_act() !== bexp) begin fails++; $display("FAIL second_edge_big got=%h want=%h", big_act(), bexp); end
    tests++;
    if (small_act() !== sexp) begin fails++; $display("FAIL second_edge_small got=%h want=%h", small_act(), sexp); end
  endtask

  task automatic test_hline();
    int hs_low = 0, va_cnt = 0, last_ls = -1, s_hs = 0, s_vs = 0, last_fs = -1;
    int max_bx = 0, max_sx = 0, max_sy = 0;
    tick(1'b0, 1'b1);
    for (int i = 0; i < 3 * 800; i++) begin
      tick(1'b1, 1'b0);
      tests++;
      if (big_act() !== bexp) begin fails++; $display("FAIL hline_big i=%0d got=%h want=%h", i, big_act(), bexp); end
      tests++;
      if (small_act() !== sexp) begin fails++; $display("FAIL hline_small i=%0d got=%h want=%h", i, small_act(), sexp); end
      if (!bhs) hs_low++;
      if (bva) va_cnt++;
      if (int'(bx) > max_bx) max_bx = int'(bx);
      if (int'(sx) > max_sx) max_sx = int'(sx);
      if (int'(sy) > max_sy) max_sy = int'(sy);
      if (bls) begin
        if (last_ls >= 0) begin
          tests++;
          if (i - last_ls != 800) begin fails++; $display("FAIL line_period got=%0d want=800", i - last_ls); end
        end
        last_ls = i;
      end
      if (i < 24 * 98) begin
        if (shs) s_hs++;
        if (svs) s_vs++;
        if (sfs) begin
          if (last_fs >= 0) begin
            tests++;
            if (i - last_fs != 98) begin fails++; $display("FAIL small_frame_period got=%0d want=98", i - last_fs); end
          end
          last_fs = i;
        end
      end
    end
    tests++;
    if (hs_low != 3 * 96) begin fails++; $display("FAIL hsync_width got=%0d want=%0d", hs_low, 3 * 96); end
    tests++;
    if (va_cnt != 3 * 640) begin fails++; $display("FAIL active_count got=%0d want=%0d", va_cnt, 3 * 640); end
    tests++;
    if (max_bx != 799) begin fails++; $display("FAIL max_x got=%0d want=799", max_bx); end
    tests++;
    if ({max_sx, max_sy} != {32'd13, 32'd6}) begin fails++; $display("FAIL small_max got=%0d,%0d want=13,6", max_sx, max_sy); end
    tests++;
    if (s_hs != 24 * 7 * 2) begin fails++; $display("FAIL small_hsync got=%0d want=%0d", s_hs, 24 * 7 * 2); end
    tests++;
    if (s_vs != 24 * 14) begin fails++; $display("FAIL small_vsync got=%0d want=%0d", s_vs, 24 * 14); end
  endtask

  task automatic test_ce_toggle();
    int last_ls = -1, n_ls = 0;
    tick(1'b0, 1'b1);
    for (int i = 0; i < 3200; i++) begin
      tick((i % 2) == 0, 1'b0);
      tests++;
      if (big_act() !== bexp) begin fails++; $display("FAIL toggle_big i=%0d got=%h want=%h", i, big_act(), bexp); end
      tests++;
      if (small_act() !== sexp) begin fails++; $display("FAIL toggle_small i=%0d got=%h want=%h", i, small_act(), sexp); end
      if (bls) begin
        n_ls++;
        if (last_ls >= 0) begin
          tests++;
          if (i - last_ls != 1600) begin fails++; $display("FAIL toggle_line_period got=%0d want=1600", i - last_ls); end
        end
        last_ls = i;
      end
    end
    tests++;
    if (n_ls != 2) begin fails++; $display("FAIL toggle_line_pulses got=%0d want=2", n_ls); end
  endtask

  task automatic test_restart();
    int n_fs = 0;
    tick(1'b0, 1'b1);
    repeat (800 + 300) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    tests++;
    if ({bx, by} !== {10'd300, 10'd1}) begin fails++; $display("FAIL restart_pos got=%0d,%0d want=300,1", bx, by); end
    tick(1'b1, 1'b0);
    tests++;
    if ({bx, by, bfs} !== {10'd0, 10'd0, 1'b1}) begin
      fails++; $display("FAIL restart_origin got=%0d,%0d fs=%b want=0,0,1", bx, by, bfs);
    end
    tick(1'b0, 1'b1);
    repeat (97) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    tests++;
    if ({sx, sy} !== {4'd13, 4'd6}) begin fails++; $display("FAIL restart_last_pos got=%0d,%0d want=13,6", sx, sy); end
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0);
      if (sfs) n_fs++;
      if (i == 0) begin
        tests++;
        if ({sx, sy, sfs} !== {4'd0, 4'd0, 1'b1}) begin
          fails++; $display("FAIL restart_last_origin got=%0d,%0d fs=%b want=0,0,1", sx, sy, sfs);
        end
      end
    end
    tests++;
    if (n_fs != 1) begin fails++; $display("FAIL restart_double_pulse got=%0d want=1", n_fs); end
  endtask

  task automatic test_async_reset();
    tick(1'b0, 1'b1);
    repeat (50) tick(1'b1, 1'b0);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if (big_act() !== B_RST) begin fails++; $display("FAIL async_reset_big got=%h want=%h", big_act(), B_RST); end
    tests++;
    if (small_act() !== S_RST) begin fails++; $display("FAIL async_reset_small got=%h want=%h", small_act(), S_RST); end
    @(posedge clk25);
    #1;
    tests++;
    if (big_act() !== B_RST) begin fails++; $display("FAIL reset_hold got=%h want=%h", big_act(), B_RST); end
    @(negedge clk25);
    rst_n = 1'b1;
    tick(1'b1, 1'b0);
    tests++;
    if ({bx, by, bfs} !== {10'd0, 10'd0, 1'b1}) begin
      fails++; $display("FAIL post_reset_origin got=%0d,%0d fs=%b want=0,0,1", bx, by, bfs);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0));
      tests++;
      if (big_act() !== bexp) begin fails++; $display("FAIL random_big i=%0d got=%h want=%h", i, big_act(), bexp); end
      tests++;
      if (small_act() !== sexp) begin fails++; $display("FAIL random_small i=%0d got=%h want=%h", i, small_act(), sexp); end
    end
  endtask

  initial begin
    test_reset();
    test_first_edge();
    test_hline();
    test_ce_toggle();
    test_restart();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
